// File: rtl/pg_prefix_pipe_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone prefix adder.
//   levels_for  : number of prefix levels (and post-capture stages) for a width
//   gp_t        : generate/propagate bit pair
//   gp_combine  : black-cell equation, hi group absorbs the lower group
package pg_prefix_pipe_pkg;

  localparam int W_DEFAULT = 8;

  function automatic int levels_for(input int w);
    return $clog2(w);
  endfunction

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/pg_prefix_pipe_if.sv
// Handshake bundle between operand source, prefix pipe and result sink.
//   in_valid/in_ready  : g/p/c_in transfer into the pipe
//   g, p, c_in         : per-bit generate/propagate vectors and carry into bit 0
//   out_valid/out_ready: sum/c_out transfer out of the pipe
//   slave  : the pipe's view; master : the source/sink view
interface pg_prefix_pipe_if
  import pg_prefix_pipe_pkg::*;
#(
  parameter int W = W_DEFAULT
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;

  modport slave (
    input  in_valid, g, p, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );

  modport master (
    output in_valid, g, p, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

endinterface

// File: rtl/pg_prefix_pipe_cell.sv
// Kogge-Stone black cell, purely combinational.
//   gh, ph : generate/propagate of the higher group
//   gl, pl : generate/propagate of the lower group
//   g, p   : combined group generate/propagate
module pg_prefix_pipe_cell
  import pg_prefix_pipe_pkg::*;
(
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  gp_t hi, lo, r;

  assign hi = {gh, ph};
  assign lo = {gl, pl};
  assign r  = gp_combine(hi, lo);
  assign g  = r.g;
  assign p  = r.p;

endmodule

// File: rtl/pg_prefix_pipe.sv
// Pipelined Kogge-Stone prefix carry network with sum stage.
// Stage 0 captures g/p (c_in folded into bit 0), then one prefix level per
// register stage; sum/c_out are decoded combinationally from the last stage.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of pg_prefix_pipe_if (valid/ready in, valid/ready out)
// A single enable (!out_valid | out_ready) advances or freezes every stage.
module pg_prefix_pipe
  import pg_prefix_pipe_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  pg_prefix_pipe_if.slave bus
);

  localparam int LEVELS = levels_for(W);

  logic         en;
  logic         vld_p    [0:LEVELS];
  logic [W-1:0] g_p      [0:LEVELS];
  logic [W-1:0] p_p      [0:LEVELS-1];
  logic [W-1:0] praw_p   [0:LEVELS];
  logic         cin_p    [0:LEVELS];

  assign en = !vld_p[LEVELS] | bus.out_ready;

  // ---- stage 0: capture, carry-in absorbed into bit-0 generate ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p[0]  <= 1'b0;
      g_p[0]    <= '0;
      p_p[0]    <= '0;
      praw_p[0] <= '0;
      cin_p[0]  <= 1'b0;
    end else if (en) begin
      vld_p[0]  <= bus.in_valid;
      g_p[0]    <= {bus.g[W-1:1], bus.g[0] | (bus.p[0] & bus.c_in)};
      p_p[0]    <= bus.p;
      praw_p[0] <= bus.p;
      cin_p[0]  <= bus.c_in;
    end
  end

  for (genvar s = 1; s <= LEVELS; s++) begin : g_lvl
    localparam int D = 1 << (s - 1);

    logic [W-1:0] g_lvl;
    logic [W-1:0] p_lvl;

    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= D) begin : g_black
        pg_prefix_pipe_cell u_cell (
          .gh (g_p[s-1][i]),
          .ph (p_p[s-1][i]),
          .gl (g_p[s-1][i-D]),
          .pl (p_p[s-1][i-D]),
          .g  (g_lvl[i]),
          .p  (p_lvl[i])
        );
      end else begin : g_pass
        assign g_lvl[i] = g_p[s-1][i];
        assign p_lvl[i] = p_p[s-1][i];
      end
    end

    // ---- stage s: register prefix level s ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p[s]  <= 1'b0;
        g_p[s]    <= '0;
        praw_p[s] <= '0;
        cin_p[s]  <= 1'b0;
      end else if (en) begin
        vld_p[s]  <= vld_p[s-1];
        g_p[s]    <= g_lvl;
        praw_p[s] <= praw_p[s-1];
        cin_p[s]  <= cin_p[s-1];
      end
    end

    // Group propagate is only consumed by later levels; the last level drops it.
    if (s < LEVELS) begin : g_keep_p
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   p_p[s] <= '0;
        else if (en)  p_p[s] <= p_lvl;
      end
    end else begin : g_drop_p
      logic [W-1:0] unused_p;
      assign unused_p = p_lvl;
    end
  end

  // ---- output: carries from final group generates ----
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_p[LEVELS];
  assign bus.sum       = praw_p[LEVELS] ^ {g_p[LEVELS][W-2:0], cin_p[LEVELS]};
  assign bus.c_out     = g_p[LEVELS][W-1];

endmodule

// File: tb/tb_pg_prefix_pipe.sv
module tb_pg_prefix_pipe;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  pg_prefix_pipe_if #(.W(8)) b8 ();
  pg_prefix_pipe_if #(.W(4)) b4 ();

  pg_prefix_pipe #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  pg_prefix_pipe #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Drive one cycle on the W=8 bus: inputs at negedge, sample just after, return at posedge.
  task automatic cyc8(input logic iv, input logic [7:0] x, input logic [7:0] y, input logic ci,
                      input logic ordy, output logic ir, output logic ov,
                      output logic [7:0] s, output logic co);
    @(negedge clk);
    b8.in_valid  = iv;
    b8.g         = x & y;
    b8.p         = x ^ y;
    b8.c_in      = ci;
    b8.out_ready = ordy;
    #1;
    ir = b8.in_ready;
    ov = b8.out_valid;
    s  = b8.sum;
    co = b8.c_out;
    @(posedge clk);
  endtask

  task automatic cyc4(input logic iv, input logic [3:0] x, input logic [3:0] y, input logic ci,
                      input logic ordy, output logic ir, output logic ov,
                      output logic [3:0] s, output logic co);
    @(negedge clk);
    b4.in_valid  = iv;
    b4.g         = x & y;
    b4.p         = x ^ y;
    b4.c_in      = ci;
    b4.out_ready = ordy;
    #1;
    ir = b4.in_ready;
    ov = b4.out_valid;
    s  = b4.sum;
    co = b4.c_out;
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic ir, ov, co;
    logic [7:0] s;
    cyc8(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, ir, ov, s, co);
    for (int j = 0; j < 4; j++) cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ir, ov, s, co);
    n_tests++;
    if (ov !== 1'b1 || s !== 8'h03) begin
      n_fail++;
      $display("FAIL reset_preload: out_valid=%b sum=%h, required 1/03", ov, s);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (b8.out_valid !== 1'b0 || b8.sum !== 8'h00 || b8.c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: out_valid=%b sum=%h c_out=%b, required 0/00/0",
               b8.out_valid, b8.sum, b8.c_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (b8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: in_ready=%b, required 1", b8.in_ready);
    end
  endtask

  task automatic test_single();
    logic ir, ov, co;
    logic [7:0] s;
    cyc8(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, ir, ov, s, co);
    n_tests++;
    if (ir !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: in_ready=%b, required 1", ir);
    end
    for (int j = 1; j <= 3; j++) begin
      cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, ir, ov, s, co);
      n_tests++;
      if (ov !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early_%0d: out_valid=%b, required 0", j, ov);
      end
    end
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, ir, ov, s, co);
    n_tests++;
    if (ov !== 1'b1 || s !== 8'h00 || co !== 1'b1) begin
      n_fail++;
      $display("FAIL single_result: out_valid=%b sum=%h c_out=%b, required 1/00/1", ov, s, co);
    end
  endtask

  task automatic test_back_to_back();
    logic ir, ov, co, iv, ci;
    logic [7:0] s, x, y;
    logic [7:0] xs[5], ys[5];
    logic       cs[5];
    int got = 0;
    q8.delete();
    for (int i = 0; i < 5; i++) begin
      xs[i] = 8'($urandom);
      ys[i] = 8'($urandom);
      cs[i] = 1'($urandom);
    end
    xs[2] = 8'h3C; ys[2] = 8'h0F; cs[2] = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      iv = (cyc < 5);
      x  = iv ? xs[cyc % 5] : 8'h00;
      y  = iv ? ys[cyc % 5] : 8'h00;
      ci = iv ? cs[cyc % 5] : 1'b0;
      cyc8(iv, x, y, ci, 1'b1, ir, ov, s, co);
      if (ov) begin
        n_tests++;
        if (q8.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: sum=%h c_out=%b, required no output", s, co);
        end else begin
          if ({co, s} !== q8[0] || cyc != 4 + got) begin
            n_fail++;
            $display("FAIL b2b_result_%0d: {c_out,sum}=%h at cycle %0d, required %h at cycle %0d",
                     got, {co, s}, cyc, q8[0], 4 + got);
          end
          void'(q8.pop_front());
        end
        if (got == 2) begin
          n_tests++;
          if (s !== 8'h4B || co !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_3c_0f: sum=%h c_out=%b, required 4B/0", s, co);
          end
        end
        got++;
      end
      if (iv) begin
        n_tests++;
        if (ir !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_accept_%0d: in_ready=%b, required 1", cyc, ir);
        end
        q8.push_back(ref8(x, y, ci));
      end
    end
    n_tests++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required 5", got);
    end
  endtask

  task automatic test_stall();
    logic ir, ov, co;
    logic [7:0] s, s0, x, y;
    logic co0, ci;
    int got = 0;
    q8.delete();
    for (int i = 0; i < 4; i++) begin
      x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
      cyc8(1'b1, x, y, ci, 1'b0, ir, ov, s, co);
      n_tests++;
      if (ir !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_fill_%0d: in_ready=%b, required 1", i, ir);
      end
      q8.push_back(ref8(x, y, ci));
    end
    s0 = 8'h00; co0 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc8(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, ir, ov, s, co);
      if (j == 0) begin
        s0 = s; co0 = co;
        n_tests++;
        if ({co, s} !== q8[0]) begin
          n_fail++;
          $display("FAIL stall_head: {c_out,sum}=%h, required %h", {co, s}, q8[0]);
        end
      end
      n_tests++;
      if (ir !== 1'b0 || ov !== 1'b1 || s !== s0 || co !== co0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: in_ready=%b out_valid=%b sum=%h c_out=%b, required 0/1/%h/%b",
                 j, ir, ov, s, co, s0, co0);
      end
    end
    x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
    cyc8(1'b1, x, y, ci, 1'b1, ir, ov, s, co);
    n_tests++;
    if (ir !== 1'b1 || ov !== 1'b1 || {co, s} !== q8[0]) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b {c_out,sum}=%h, required 1/1/%h",
               ir, ov, {co, s}, q8[0]);
    end
    void'(q8.pop_front());
    got++;
    q8.push_back(ref8(x, y, ci));
    for (int cyc = 0; cyc < 15; cyc++) begin
      cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, ir, ov, s, co);
      if (ov) begin
        n_tests++;
        if (q8.size() == 0) begin
          n_fail++;
          $display("FAIL stall_dup: extra result %h, required none", {co, s});
        end else begin
          if ({co, s} !== q8[0]) begin
            n_fail++;
            $display("FAIL stall_drain_%0d: {c_out,sum}=%h, required %h", got, {co, s}, q8[0]);
          end
          void'(q8.pop_front());
        end
        got++;
      end
    end
    n_tests++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL stall_count: got %0d results, required 5", got);
    end
  endtask

  task automatic test_reset_midstream();
    logic ir, ov, co;
    logic [7:0] s;
    int got = 0;
    for (int i = 0; i < 3; i++)
      cyc8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, ir, ov, s, co);
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ir, ov, s, co);
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ir, ov, s, co);
    n_tests++;
    if (ov !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_loaded: out_valid=%b, required 1", ov);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (b8.out_valid !== 1'b0 || b8.sum !== 8'h00 || b8.c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: out_valid=%b sum=%h c_out=%b, required 0/00/0",
               b8.out_valid, b8.sum, b8.c_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc8(1'b1, 8'h80, 8'h80, 1'b0, 1'b1, ir, ov, s, co);
    for (int cyc = 1; cyc < 12; cyc++) begin
      cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, ir, ov, s, co);
      if (ov) begin
        n_tests++;
        if (cyc != 4 || s !== 8'h00 || co !== 1'b1) begin
          n_fail++;
          $display("FAIL midrst_result: cycle %0d sum=%h c_out=%b, required cycle 4 00/1", cyc, s, co);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 1) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d results, required 1", got);
    end
  endtask

  task automatic test_w4_exhaustive();
    logic ir, ov, co, iv, ordy;
    logic [3:0] s;
    logic [8:0] v;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    q4.delete();
    while (got < 512 && cyc < 6000) begin
      iv   = (idx < 512) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      v    = 9'(idx);
      cyc4(iv, v[8:5], v[4:1], v[0], ordy, ir, ov, s, co);
      if (ov && ordy) begin
        n_tests++;
        if (q4.size() == 0) begin
          n_fail++;
          $display("FAIL w4_extra: {c_out,sum}=%h, required none", {co, s});
        end else begin
          if ({co, s} !== q4[0]) begin
            n_fail++;
            $display("FAIL w4_result_%0d: {c_out,sum}=%h, required %h", got, {co, s}, q4[0]);
          end
          void'(q4.pop_front());
        end
        got++;
      end
      if (iv && ir) begin
        q4.push_back({1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'd0, v[0]});
        idx++;
      end
      cyc++;
    end
    n_tests++;
    if (got != 512 || q4.size() != 0) begin
      n_fail++;
      $display("FAIL w4_count: got %0d results with %0d pending, required 512 and 0", got, q4.size());
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    b8.in_valid  = 1'b0;
    b8.g         = '0;
    b8.p         = '0;
    b8.c_in      = 1'b0;
    b8.out_ready = 1'b0;
    b4.in_valid  = 1'b0;
    b4.g         = '0;
    b4.p         = '0;
    b4.c_in      = 1'b0;
    b4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_w4_exhaustive();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
